// File: rtl/ysyx_220066_mem_arb.sv
// Shared data-memory port arbiter: IF vs M grant, one outstanding transaction.
// Optional response watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module ysyx_220066_mem_arb #(
    parameter logic [2:0] IF_OP      = 3'b010,
    parameter int         MAX_STREAK = 4,
    parameter int         TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic        m_rd,
    input  logic        m_wr,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    input  logic [2:0]  m_op,
    output logic        if_block,
    output logic        m_block,
    output logic        if_rsp_valid,
    output logic        m_rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wr,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [2:0]  mem_op,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    localparam int SW = $clog2(MAX_STREAK + 1);

    state_t        state;
    logic [SW-1:0] streak;
    logic          gnt_if;
    logic          lat_wr;
    logic [2:0]    lat_op;
    logic [63:0]   lat_addr;
    logic [63:0]   lat_wdata;

    logic any_m;
    logic any_req;
    logic pick_if;
    logic tmo;
    logic done;

    assign any_m   = m_rd | m_wr;
    assign any_req = if_req | any_m;
    // M wins unless IF is alone or has been starved for MAX_STREAK grants
    assign pick_if = if_req && (!any_m || streak == SW'(MAX_STREAK));

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WDW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [WDW-1:0] wdog;

    assign tmo = (state == WAIT) && !mem_rsp_valid && (wdog == WDW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= '0;
        end else if (state == REQ && mem_req_ready) begin
            wdog <= '0;
        end else if (state == WAIT && !done) begin
            wdog <= wdog + 1'b1;
        end
    end

    assign rsp_err   = tmo;
    assign rsp_rdata = tmo ? 64'd0 : mem_rsp_rdata;
`else
    assign tmo       = 1'b0;
    assign rsp_err   = 1'b0;
    assign rsp_rdata = mem_rsp_rdata;
`endif

    assign done         = (state == WAIT) && (mem_rsp_valid || tmo);
    assign if_rsp_valid = done && gnt_if;
    assign m_rsp_valid  = done && !gnt_if;

    assign if_block = if_req && !if_rsp_valid;
    assign m_block  = any_m && !m_rsp_valid;

    assign mem_wr    = lat_wr;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_op    = lat_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            streak        <= '0;
            gnt_if        <= 1'b0;
            lat_wr        <= 1'b0;
            lat_op        <= 3'b000;
            lat_addr      <= 64'd0;
            lat_wdata     <= 64'd0;
            mem_req_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!if_req) begin
                        streak <= '0;
                    end
                    if (any_req) begin
                        state         <= REQ;
                        mem_req_valid <= 1'b1;
                        gnt_if        <= pick_if;
                        if (pick_if) begin
                            streak    <= '0;
                            lat_wr    <= 1'b0;
                            lat_addr  <= if_addr;
                            lat_wdata <= 64'd0;
                            lat_op    <= IF_OP;
                        end else begin
                            if (if_req && streak != SW'(MAX_STREAK)) begin
                                streak <= streak + 1'b1;
                            end
                            lat_wr    <= m_wr;
                            lat_addr  <= m_addr;
                            lat_wdata <= m_wdata;
                            lat_op    <= m_op;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state         <= WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_220066_mem_arb.sv
// Directed bench for ysyx_220066_mem_arb: vector table plus multi-cycle sequences.
module tb_ysyx_220066_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic        m_rd;
    logic        m_wr;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [2:0]  m_op;
    logic        if_block;
    logic        m_block;
    logic        if_rsp_valid;
    logic        m_rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wr;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [2:0]  mem_op;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ysyx_220066_mem_arb #(
        .IF_OP(3'b010),
        .MAX_STREAK(4),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .if_req(if_req),
        .if_addr(if_addr),
        .m_rd(m_rd),
        .m_wr(m_wr),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .m_op(m_op),
        .if_block(if_block),
        .m_block(m_block),
        .if_rsp_valid(if_rsp_valid),
        .m_rsp_valid(m_rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_wr(mem_wr),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_op(mem_op),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata)
    );

    typedef struct {
        logic        ifr;
        logic [63:0] ifa;
        logic        mrd;
        logic        mwr;
        logic [63:0] ma;
        logic [63:0] mwd;
        logic [2:0]  mop;
        logic [63:0] rdata;
        logic        exp_if;
        logic        exp_wr;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [2:0]  exp_op;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        logic mreq;
        mreq = v.mrd | v.mwr;
        @(posedge clk);
        #1;
        if_req        = v.ifr;
        if_addr       = v.ifa;
        m_rd          = v.mrd;
        m_wr          = v.mwr;
        m_addr        = v.ma;
        m_wdata       = v.mwd;
        m_op          = v.mop;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = v.rdata;
        @(negedge clk);
        chk($sformatf("v%0d_c0_req_valid", i), 64'(mem_req_valid), 64'd0);
        chk($sformatf("v%0d_c0_if_block", i), 64'(if_block), 64'(v.ifr));
        chk($sformatf("v%0d_c0_m_block", i), 64'(m_block), 64'(mreq));
        @(negedge clk);
        chk($sformatf("v%0d_c1_req_valid", i), 64'(mem_req_valid), 64'd1);
        chk($sformatf("v%0d_c1_addr", i), mem_addr, v.exp_addr);
        chk($sformatf("v%0d_c1_wr", i), 64'(mem_wr), 64'(v.exp_wr));
        chk($sformatf("v%0d_c1_wdata", i), mem_wdata, v.exp_wdata);
        chk($sformatf("v%0d_c1_op", i), 64'(mem_op), 64'(v.exp_op));
        chk($sformatf("v%0d_c1_m_block", i), 64'(m_block), 64'(mreq));
        chk($sformatf("v%0d_c1_no_rsp", i), 64'({if_rsp_valid, m_rsp_valid}), 64'd0);
        @(negedge clk);
        chk($sformatf("v%0d_c2_if_rsp", i), 64'(if_rsp_valid), 64'(v.exp_if));
        chk($sformatf("v%0d_c2_m_rsp", i), 64'(m_rsp_valid), 64'(!v.exp_if));
        chk($sformatf("v%0d_c2_rdata", i), rsp_rdata, v.rdata);
        chk($sformatf("v%0d_c2_err", i), 64'(rsp_err), 64'd0);
        chk($sformatf("v%0d_c2_if_block", i), 64'(if_block), 64'(v.ifr && !v.exp_if));
        chk($sformatf("v%0d_c2_m_block", i), 64'(m_block), 64'(mreq && v.exp_if));
        @(posedge clk);
        #1;
        if_req        = 1'b0;
        m_rd          = 1'b0;
        m_wr          = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        int exp_g[10];
        int n;
        bit seen;

        vecs[0] = '{1'b1, 64'h1000, 1'b0, 1'b0, 64'h0, 64'h0, 3'b000,
                    64'h1111_2222_3333_4444, 1'b1, 1'b0, 64'h1000, 64'h0, 3'b010};
        vecs[1] = '{1'b0, 64'h0, 1'b0, 1'b1, 64'h8000_0010, 64'hDEAD_BEEF, 3'b011,
                    64'h0, 1'b0, 1'b1, 64'h8000_0010, 64'hDEAD_BEEF, 3'b011};
        vecs[2] = '{1'b1, 64'h2000, 1'b1, 1'b0, 64'h8000_0100, 64'h0, 3'b100,
                    64'hCAFE_F00D, 1'b0, 1'b0, 64'h8000_0100, 64'h0, 3'b100};
        vecs[3] = '{1'b1, 64'h3000, 1'b0, 1'b0, 64'h9000, 64'hFFFF, 3'b111,
                    64'h77, 1'b1, 1'b0, 64'h3000, 64'h0, 3'b010};
        exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        rst_n         = 1'b0;
        if_req        = 1'b1;
        if_addr       = 64'hA0;
        m_rd          = 1'b0;
        m_wr          = 1'b0;
        m_addr        = 64'h0;
        m_wdata       = 64'h0;
        m_op          = 3'b000;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 64'h0;

        // Reset held with a fetch pending
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_if_block", 64'(if_block), 64'd1);
        chk("rst_rsp", 64'({if_rsp_valid, m_rsp_valid}), 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_c0_req_valid", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        chk("rel_c1_addr", mem_addr, 64'hA0);
        chk("rel_c1_wr", 64'(mem_wr), 64'd0);
        chk("rel_c1_op", 64'(mem_op), 64'(3'b010));
        // Ready withheld: request must hold steady
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("stall%0d_req_valid", k), 64'(mem_req_valid), 64'd1);
            chk($sformatf("stall%0d_addr", k), mem_addr, 64'hA0);
        end
        @(posedge clk);
        #1;
        mem_req_ready = 1'b1;
        @(posedge clk);
        #3;
        // Async reset in WAIT with a response arriving at the same time
        rst_n         = 1'b0;
        mem_rsp_valid = 1'b1;
        #1;
        chk("arst_if_rsp", 64'(if_rsp_valid), 64'd0);
        chk("arst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("arst_err", 64'(rsp_err), 64'd0);
        chk("arst_if_block", 64'(if_block), 64'd1);
        chk("arst_addr", mem_addr, 64'd0);
        if_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_late_rsp", 64'({if_rsp_valid, m_rsp_valid}), 64'd0);
        chk("arst_idle", 64'(mem_req_valid), 64'd0);
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Fairness under continuous contention
        @(posedge clk);
        #1;
        if_req        = 1'b1;
        if_addr       = 64'h1111_0000;
        m_rd          = 1'b1;
        m_addr        = 64'h2222_0000;
        m_op          = 3'b011;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 80 && n < 10; c++) begin
            @(negedge clk);
            chk($sformatf("excl_c%0d", c), 64'(if_rsp_valid & m_rsp_valid), 64'd0);
            if (mem_req_valid) begin
                chk($sformatf("grant%0d", n), 64'(mem_addr == 64'h1111_0000), 64'(exp_g[n]));
                n++;
            end
        end
        chk("grant_count", 64'(n), 64'd10);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        m_rd   = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;

        // Response withheld
        m_rd          = 1'b1;
        m_addr        = 64'h3000;
        mem_rsp_rdata = 64'h1234;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (mem_req_valid) seen = 1'b1;
        end
        chk("wd_req_seen", 64'(seen), 64'd1);
`ifdef MEM_ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("wd_k%0d_quiet", k), 64'(m_rsp_valid), 64'd0);
        end
        @(negedge clk);
        chk("wd_pulse", 64'(m_rsp_valid), 64'd1);
        chk("wd_err", 64'(rsp_err), 64'd1);
        chk("wd_rdata", rsp_rdata, 64'd0);
        @(posedge clk);
        #1;
        m_rd          = 1'b0;
        mem_rsp_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("wd_late_rsp", 64'({if_rsp_valid, m_rsp_valid}), 64'd0);
        end
        mem_rsp_valid = 1'b0;
`else
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_rsp_valid || rsp_err) n++;
        end
        chk("hold_no_pulse", 64'(n), 64'd0);
        chk("hold_block", 64'(m_block), 64'd1);
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("hold_pulse", 64'(m_rsp_valid), 64'd1);
        chk("hold_rdata", rsp_rdata, 64'h1234);
        chk("hold_err", 64'(rsp_err), 64'd0);
        chk("hold_unblock", 64'(m_block), 64'd0);
        @(posedge clk);
        #1;
        m_rd          = 1'b0;
        mem_rsp_valid = 1'b0;
`endif
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ysyx_220066_mem_arb.md
# ysyx_220066_mem_arb

Arbiter and sequencer for the single shared data-memory port of the ysyx_220066 core. Two requesters compete for the port: the instruction-fetch stage (read-only) and the M stage (load/store). The block grants one requester at a time and runs exactly one outstanding transaction through a request/response handshake. It routes the response back to the granted requester and produces the per-requester stall signals that drive the pipeline `block` inputs.

## Interface
- `IF_OP`, 3'b010: MemOp value presented on `mem_op` for fetch requests.
- `MAX_STREAK`, 4: consecutive M grants allowed while a fetch is waiting; after that, IF is forced.
- `TIMEOUT`, 255: response watchdog limit in cycles; used only with `MEM_ARB_TIMEOUT_EN`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request; held high with `if_addr` stable until `if_rsp_valid`.
- `if_addr` in 64: fetch address.
- `m_rd`, `m_wr` in 1: M-stage load / store request (mutually exclusive); held until `m_rsp_valid`.
- `m_addr` in 64, `m_wdata` in 64, `m_op` in 3: M-stage address, store data, MemOp.
- `if_block`, `m_block` out 1: stall to the requester: `req && !rsp_valid` (combinational).
- `if_rsp_valid`, `m_rsp_valid` out 1: one-cycle completion pulse to the granted requester.
- `rsp_rdata` out 64: read data, valid with either rsp pulse.
- `rsp_err` out 1: error flag, valid with either rsp pulse.
- `mem_req_valid` out 1, `mem_req_ready` in 1: downstream request handshake.
- `mem_wr` out 1, `mem_addr` out 64, `mem_wdata` out 64, `mem_op` out 3: downstream request fields.
- `mem_rsp_valid` in 1, `mem_rsp_rdata` in 64: downstream response.

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE → REQ** when `if_req | m_rd | m_wr`. The grant decision and all request fields are latched into registers on this edge.
- **Grant rule**: M has priority. IF wins if it is the only requester, or if the streak counter equals `MAX_STREAK`.
- **Streak counter** (width `$clog2(MAX_STREAK+1)`):
  - increments on an M grant taken while `if_req` is high;
  - clears on any IF grant, and in any IDLE cycle with `if_req` low;
  - saturates at `MAX_STREAK`.
- **REQ**: `mem_req_valid`=1 and the latched fields are driven. REQ → WAIT when `mem_req_ready`=1.
- **WAIT**: `mem_req_valid`=0. When `mem_rsp_valid`=1:
  - assert the granted requester's rsp pulse;
  - drive `rsp_rdata`=`mem_rsp_rdata` combinationally, with `rsp_err`=0;
  - return to IDLE.
- Fetch requests drive `mem_wr`=0, `mem_wdata`=0, `mem_op`=`IF_OP`.
- Store responses still pulse `m_rsp_valid`; the value on `rsp_rdata` is don't-care.
- `mem_rsp_valid` arriving in IDLE or REQ is ignored.
- The `*_rsp_valid` pulses are never both high in the same cycle.

## Timing
- Reset values: state=IDLE, streak=0. Latched grant, write flag and op reset to 0; latched addr and wdata reset to 0. `mem_req_valid`=0, `if_rsp_valid`=`m_rsp_valid`=0, `rsp_err`=0. `*_block` follow the inputs even during reset.
- Minimum latency:
  - request seen in IDLE at cycle 0;
  - `mem_req_valid` high at cycle 1;
  - with ready at cycle 1, WAIT at cycle 2;
  - rsp pulse at cycle 2 at the earliest.
- After a response the FSM is in IDLE for at least one cycle. A requester still asserting its request in that IDLE cycle starts a new transaction.
- If a requester drops its request while in REQ or WAIT, the transaction still completes. The rsp pulse is still delivered, and the requester ignores it.
- Reset asserted mid-transaction: immediate return to IDLE. Any in-flight downstream response is dropped.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - an 8-bit-or-wider watchdog counts cycles in WAIT and clears on entering WAIT;
  - when the count reaches `TIMEOUT` with no `mem_rsp_valid`, pulse the granted rsp with `rsp_err`=1 and `rsp_rdata`=0, then go to IDLE;
  - a late `mem_rsp_valid` is then ignored.
- Undefined: no watchdog logic; `rsp_err` is constant 0, and WAIT holds until `mem_rsp_valid`.

## Test plan
- Reset with `if_req`=1 held, then release. Required:
  - `mem_req_valid` first high one cycle after release;
  - `mem_addr`=`if_addr`, `mem_wr`=0, `mem_op`=3'b010.
- `m_wr`=1, `m_addr`=0x80000010, `m_wdata`=0xDEADBEEF, ready and response immediate. Required:
  - `m_rsp_valid` at cycle 2;
  - `m_block` high in cycles 0-1 and low at cycle 2.
- `if_req` and `m_rd` high continuously, `MAX_STREAK`=4, zero-wait memory. Required: grant sequence M,M,M,M,IF,M,M,M,M,IF.
- `mem_req_ready` held low for 5 cycles. Required:
  - `mem_req_valid` stays high;
  - `mem_addr` is unchanged throughout;
  - the FSM stays in REQ.
- Response withheld with `MEM_ARB_TIMEOUT_EN`, `TIMEOUT`=8. Required:
  - error pulse exactly 8 cycles after entering WAIT, with `rsp_err`=1 and `rsp_rdata`=0;
  - a later `mem_rsp_valid` produces no pulse.
- `rst_n` pulsed low during WAIT. Required:
  - outputs go to their reset values asynchronously;
  - a subsequent `mem_rsp_valid` is ignored.
